// File: rtl/phantom_clock_gate.sv
// phantom_clock_gate
//   In-CPLD replacement for a DS1215-style phantom clock. Watches the RAM
//   access stream for the 64-bit unlock pattern written LSB-first on D0.
//   While hunting, the SRAM chip-select passes straight through. Once
//   unlocked, a window of XFER_BITS accesses is redirected to a 64-bit shift
//   register that is loaded from, and optionally written back to, an
//   external timekeeper.
//
// Ports
//   C7M        in   system clock, all state changes on posedge
//   RES        in   asynchronous active-high reset
//   RAMROMCS   in   raw RAM/ROM chip-select
//   ACC        in   one-cycle strobe per completed access
//   ACCWR      in   access direction (1 = write), qualified by ACC
//   DIN        in   data bit D0, qualified by ACC
//   RAMROMCSgb out  gated chip-select to the SRAM/ROM path
//   DOUT       out  clock bit to drive on D0 during unlocked reads
//   DOE        out  select logic drives D0 from DOUT when high
//   TimeIn     in   timekeeper snapshot, latched at unlock
//   TimeOut    out  value assembled by a transfer containing writes
//   TimeWR     out  one-cycle load strobe for TimeOut
//   Unlocked   out  transfer window active
module phantom_clock_gate #(
  parameter logic [63:0] PATTERN   = 64'h5CA33AC55CA33AC5,
  parameter int unsigned XFER_BITS = 64
) (
  input  logic        C7M,
  input  logic        RES,
  input  logic        RAMROMCS,
  input  logic        ACC,
  input  logic        ACCWR,
  input  logic        DIN,
  output logic        RAMROMCSgb,
  output logic        DOUT,
  output logic        DOE,
  input  logic [63:0] TimeIn,
  output logic [63:0] TimeOut,
  output logic        TimeWR,
  output logic        Unlocked
);

  typedef enum logic {HUNT, XFER} state_t;

  localparam logic [6:0] XFER_END = 7'(XFER_BITS);

  state_t      state, state_nx;
  logic [6:0]  cnt, cnt_nx, cnt_inc;
  logic [63:0] shreg, shreg_nx;
  logic        dirty, dirty_nx;
  logic [63:0] timeout_nx;
  logic        timewr_nx;

  always_ff @(posedge C7M or posedge RES) begin
    if (RES) begin
      state <= HUNT;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge C7M or posedge RES) begin
    if (RES) begin
      cnt     <= '0;
      shreg   <= '0;
      dirty   <= 1'b0;
      TimeOut <= '0;
      TimeWR  <= 1'b0;
    end else begin
      cnt     <= cnt_nx;
      shreg   <= shreg_nx;
      dirty   <= dirty_nx;
      TimeOut <= timeout_nx;
      TimeWR  <= timewr_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    cnt_inc    = cnt + 7'd1;
    shreg_nx   = shreg;
    dirty_nx   = dirty;
    timeout_nx = TimeOut;
    timewr_nx  = 1'b0;
    RAMROMCSgb = RAMROMCS;
    DOE        = 1'b0;

    case (state)
      HUNT: begin
        if (ACC) begin
          if (ACCWR) begin
            if (DIN == PATTERN[cnt[5:0]]) begin
              if (cnt_inc == 7'd64) begin
                state_nx = XFER;
                cnt_nx   = '0;
                shreg_nx = TimeIn;
                dirty_nx = 1'b0;
              end else begin
                cnt_nx = cnt_inc;
              end
            end else begin
              // Only a restart on the first pattern bit is recognised.
              cnt_nx = {6'd0, DIN == PATTERN[0]};
            end
          end else begin
            cnt_nx = '0;
          end
        end
      end

      XFER: begin
        RAMROMCSgb = 1'b0;
        DOE        = RAMROMCS & ~ACCWR;
        if (ACC) begin
          // Reads recirculate bit 0 so a full window leaves the value intact.
          shreg_nx = {(ACCWR ? DIN : shreg[0]), shreg[63:1]};
          dirty_nx = dirty | ACCWR;
          if (cnt_inc == XFER_END) begin
            state_nx = HUNT;
            cnt_nx   = '0;
            if (dirty | ACCWR) begin
              timeout_nx = shreg_nx;
              timewr_nx  = 1'b1;
            end
          end else begin
            cnt_nx = cnt_inc;
          end
        end
      end

      default: state_nx = HUNT;
    endcase
  end

  assign DOUT     = shreg[0];
  assign Unlocked = (state == XFER);

endmodule

// File: tb/tb_phantom_clock_gate.sv
// tb_phantom_clock_gate
//   Self-checking bench for phantom_clock_gate: select-gating vector table,
//   directed unlock/transfer sequences and randomized sessions against a
//   queue-based reference model.
module tb_phantom_clock_gate;

  logic        C7M = 1'b0;
  logic        RES, RAMROMCS, ACC, ACCWR, DIN;
  logic [63:0] TimeIn, TimeOut;
  logic        RAMROMCSgb, DOUT, DOE, TimeWR, Unlocked;

  int checks = 0;
  int errors = 0;

  logic [63:0] pat;

  // Reference model state
  bit          m_unl;
  int          m_hits;
  bit          m_q[$];
  int          m_n;
  bit          m_dirty;
  logic [63:0] m_tout;
  bit          m_twr;

  typedef struct {
    bit xfer;
    bit cs;
    bit wr;
    bit gb;
    bit doe;
  } vec_t;
  vec_t tbl[8];

  phantom_clock_gate #(
    .PATTERN  (64'h5CA33AC55CA33AC5),
    .XFER_BITS(64)
  ) dut (
    .C7M       (C7M),
    .RES       (RES),
    .RAMROMCS  (RAMROMCS),
    .ACC       (ACC),
    .ACCWR     (ACCWR),
    .DIN       (DIN),
    .RAMROMCSgb(RAMROMCSgb),
    .DOUT      (DOUT),
    .DOE       (DOE),
    .TimeIn    (TimeIn),
    .TimeOut   (TimeOut),
    .TimeWR    (TimeWR),
    .Unlocked  (Unlocked)
  );

  always #5 C7M = ~C7M;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_unl   = 1'b0;
    m_hits  = 0;
    m_q.delete();
    m_n     = 0;
    m_dirty = 1'b0;
    m_tout  = '0;
    m_twr   = 1'b0;
  endtask

  task automatic model_access(input bit wr, input bit din);
    m_twr = 1'b0;
    if (!m_unl) begin
      if (wr) begin
        if (din == pat[m_hits]) m_hits++;
        else m_hits = (din == pat[0]) ? 1 : 0;
        if (m_hits == 64) begin
          m_unl  = 1'b1;
          m_hits = 0;
          m_q.delete();
          for (int i = 0; i < 64; i++) m_q.push_back(TimeIn[i]);
          m_n     = 0;
          m_dirty = 1'b0;
        end
      end else begin
        m_hits = 0;
      end
    end else begin
      bit b;
      b = m_q.pop_front();
      m_q.push_back(wr ? din : b);
      if (wr) m_dirty = 1'b1;
      m_n++;
      if (m_n == 64) begin
        m_unl = 1'b0;
        if (m_dirty) begin
          for (int i = 0; i < 64; i++) m_tout[i] = m_q[i];
          m_twr = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all();
    logic exp_dout;
    exp_dout = (m_q.size() > 0) ? m_q[0] : 1'b0;
    chk("Unlocked",   64'(Unlocked),   64'(m_unl));
    chk("DOUT",       64'(DOUT),       64'(exp_dout));
    chk("RAMROMCSgb", 64'(RAMROMCSgb), 64'(m_unl ? 1'b0 : RAMROMCS));
    chk("DOE",        64'(DOE),        64'(m_unl & RAMROMCS & ~ACCWR));
    chk("TimeWR",     64'(TimeWR),     64'(m_twr));
    chk("TimeOut",    TimeOut,         m_tout);
  endtask

  task automatic do_reset();
    RES = 1'b1; RAMROMCS = 1'b0; ACC = 1'b0; ACCWR = 1'b0; DIN = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge C7M); #1;
    RES = 1'b0;
  endtask

  // One ACC cycle, checked just after the sampling edge.
  task automatic access(input bit wr, input bit din, input bit cs);
    RAMROMCS = cs; ACCWR = wr; DIN = din; ACC = 1'b1;
    @(posedge C7M); #1;
    ACC = 1'b0;
    model_access(wr, din);
    check_all();
  endtask

  task automatic idle();
    @(posedge C7M); #1;
    m_twr = 1'b0;
    check_all();
  endtask

  task automatic acc_idle(input bit wr, input bit din, input bit cs);
    access(wr, din, cs);
    idle();
  endtask

  task automatic write_pattern(input int n);
    for (int i = 0; i < n; i++) acc_idle(1'b1, pat[i], 1'b1);
  endtask

  task automatic apply_tbl(input bit phase);
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].xfer == phase) begin
        RAMROMCS = tbl[i].cs; ACCWR = tbl[i].wr; ACC = 1'b0;
        #1;
        chk("tbl_gb",  64'(RAMROMCSgb), 64'(tbl[i].gb));
        chk("tbl_doe", 64'(DOE),        64'(tbl[i].doe));
      end
    end
  endtask

  initial begin
    logic [63:0] v, t, e;
    pat = 64'h5CA33AC55CA33AC5;

    //          xfer  cs    wr    gb    doe
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    TimeIn = '0;

    // 1: unlock and read back the snapshot without writing
    do_reset();
    apply_tbl(1'b0);
    TimeIn = 64'h0123456789ABCDEF;
    write_pattern(64);
    chk("t1_unlocked", 64'(Unlocked), 64'd1);
    v = TimeIn;
    for (int i = 0; i < 64; i++) begin
      chk("t1_dout", 64'(DOUT), 64'(v[i]));
      acc_idle(1'b0, 1'b0, 1'b1);
    end
    chk("t1_unlocked_end", 64'(Unlocked), 64'd0);
    RAMROMCS = 1'b1; #1;
    chk("t1_gb_after", 64'(RAMROMCSgb), 64'd1);

    // 2: corrupted bit 10 must not unlock
    do_reset();
    for (int i = 0; i < 64; i++) acc_idle(1'b1, (i == 10) ? ~pat[i] : pat[i], 1'b1);
    chk("t2_locked", 64'(Unlocked), 64'd0);

    // 3: a read aborts a partial pattern
    do_reset();
    write_pattern(30);
    acc_idle(1'b0, 1'b0, 1'b1);
    write_pattern(63);
    chk("t3_not_yet", 64'(Unlocked), 64'd0);
    acc_idle(1'b1, pat[63], 1'b1);
    chk("t3_unlocked", 64'(Unlocked), 64'd1);
    for (int i = 0; i < 64; i++) acc_idle(1'b0, 1'b0, 1'b1);

    // 4: full write transfer
    do_reset();
    TimeIn = {$urandom, $urandom};
    write_pattern(64);
    apply_tbl(1'b1);
    v = 64'hFEDCBA9876543210;
    for (int i = 0; i < 63; i++) acc_idle(1'b1, v[i], 1'b1);
    access(1'b1, v[63], 1'b1);
    chk("t4_timewr", 64'(TimeWR), 64'd1);
    chk("t4_timeout", TimeOut, v);
    idle();
    chk("t4_timewr_end", 64'(TimeWR), 64'd0);

    // 5: reset in the middle of a transfer
    do_reset();
    write_pattern(64);
    for (int i = 0; i < 20; i++) acc_idle(1'b0, 1'b0, 1'b1);
    RAMROMCS = 1'b1; RES = 1'b1;
    #1;
    chk("t5_unlocked", 64'(Unlocked), 64'd0);
    chk("t5_gb", 64'(RAMROMCSgb), 64'd1);
    model_reset();
    check_all();
    @(posedge C7M); #1;
    RES = 1'b0;
    for (int i = 0; i < 64; i++) acc_idle(1'b0, 1'b0, 1'b1);
    chk("t5_still_locked", 64'(Unlocked), 64'd0);

    // 6: final write alone still commits
    do_reset();
    t = {$urandom, $urandom};
    TimeIn = t;
    write_pattern(64);
    for (int i = 0; i < 63; i++) acc_idle(1'b0, 1'b0, 1'b1);
    access(1'b1, 1'b1, 1'b1);
    e = t;
    e[63] = 1'b1;
    chk("t6_timewr", 64'(TimeWR), 64'd1);
    chk("t6_timeout", TimeOut, e);
    idle();

    // Randomized sessions; TimeIn wanders to show it is only latched once
    do_reset();
    for (int s = 0; s < 25; s++) begin
      for (int i = 0; i < 8; i++) begin
        TimeIn = {$urandom, $urandom};
        access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
        repeat ($urandom_range(0, 2)) idle();
      end
      for (int i = 0; i < 64; i++) begin
        TimeIn = {$urandom, $urandom};
        access(1'b1, ($urandom_range(0, 99) < 3) ? ~pat[i] : pat[i],
               1'($urandom_range(0, 3) != 0));
        repeat ($urandom_range(0, 2)) idle();
      end
      for (int i = 0; i < 64; i++) begin
        TimeIn = {$urandom, $urandom};
        access(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 3) != 0));
        repeat ($urandom_range(0, 2)) idle();
      end
      idle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
